lut_1596_arb: RTL and testbench
===============================

# lut_1596_arb

Two-port round-robin arbiter and sequencer for the shared `lut_1596` decoder. Two requesters present 4-bit codes with a valid/ready handshake; one lookup is granted per cycle and the registered 1-bit result is returned to the granted requester one cycle later. An optional self-test sweep walks all 16 codes through the decoder and counts hits. The block sits between the nibble producers and the single `lut_1596` instance; the hit set is the one defined in `defines.sh` (`` `Aone``, `` `Bone``, `` `Cone``).

## Interface
- `HIT_W`, default 5: width of `sweep_hits`. Must be at least 5 so a count of 16 is representable.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0_valid` in 1: requester 0 presents a code.
- `req0_x` in 4: requester 0 code.
- `req0_ready` out 1: requester 0 granted this cycle (combinational).
- `rsp0_valid` out 1: one-cycle pulse, result for requester 0.
- `rsp0_y` out 1: decoder result for requester 0.
- `req1_valid`, `req1_x`, `req1_ready`, `rsp1_valid`, `rsp1_y`: same as port 0, for requester 1.
- `sweep_start` in 1: start a self-test sweep.
- `sweep_busy` out 1: sweep in progress.
- `sweep_done` out 1: one-cycle pulse, sweep finished.
- `sweep_hits` out `HIT_W`: hit count of the last completed sweep.

## Operation
- FSM states are IDLE and SWEEP. SWEEP exists only with `LUT_SWEEP_EN`.
- Requests are served in IDLE only.
- **Arbitration**
  - A request is accepted on a cycle where `reqN_valid && reqN_ready`.
  - With only one requester valid, that requester gets ready.
  - With both valid, ready goes to the port not granted most recently.
  - The round-robin pointer updates only on an accept. After reset the pointer favours port 0.
  - `req0_ready` and `req1_ready` are never high together.
  - Ready is low in SWEEP, and low in any cycle where `sweep_start` is sampled in IDLE.
- **Lookup**
  - The accepted code drives the `lut_1596` instance `x`.
  - `y` is registered into `rspN_y`, and `rspN_valid` pulses for the granted port only.
  - The non-granted `rspN_y` holds its previous value.
- **Sweep**
  - `sweep_start` high in IDLE resets the index and hit counter to 0 and moves the FSM to SWEEP.
  - In SWEEP, the index drives the decoder, the counter increments on `y`=1, and the index increments.
  - After index 15 is evaluated, the FSM returns to IDLE and pulses `sweep_done`.
  - `sweep_hits` is updated at sweep end and holds until the next sweep ends.
  - `sweep_start` is ignored while in SWEEP.
  - Requests asserted during SWEEP are held off, not dropped; the requester keeps valid high.
- **Reset** (asynchronous, any time, including mid-sweep)
  - Outputs: `rsp*_valid`=0, `rsp*_y`=0, `sweep_busy`=0, `sweep_done`=0, `sweep_hits`=0.
  - State: IDLE, pointer favouring port 0, index 0.
  - An aborted sweep produces no `sweep_done`.

## Timing
- Lookup latency: accept at edge t gives `rspN_valid`/`rspN_y` in the cycle after edge t. Throughput is one lookup per cycle.
- Ready is combinational from `reqN_valid`, the pointer and the state. There is no backpressure on responses.
- Sweep, with `sweep_start` sampled at edge t:
  - `sweep_busy` is high for exactly 16 cycles, evaluating codes 0..15 in order.
  - The next cycle has `sweep_done`=1, the final `sweep_hits`, `sweep_busy`=0, and requests accepted again.
- A sweep takes 17 cycles from the start edge to `sweep_done`.

## Configuration
- `LUT_SWEEP_EN` defined:
  - The SWEEP state, index counter and hit counter are built.
  - `sweep_*` ports behave as specified above.
- `LUT_SWEEP_EN` undefined:
  - The ports remain present. `sweep_start` is ignored; `sweep_busy`, `sweep_done` and `sweep_hits` are tied to 0.
  - The FSM is IDLE only, and arbitration is never blocked.

## Test plan
- Reset behaviour: drive `rst` high mid-traffic → all outputs 0 immediately. After release, both ports valid → `req0_ready`=1 first.
- Single requester: `req1_valid`=1 with `req1_x`=`` `Bone`` → next cycle `rsp1_valid`=1, `rsp1_y`=1, `rsp0_valid`=0. Repeat with a non-hit code → `rsp1_y`=0.
- Round robin: both valid continuously for 6 cycles → grants 0,1,0,1,0,1. Drop port 1 for 2 cycles → port 0 granted on both.
- Sweep (macro on): pulse `sweep_start` → `sweep_busy` high 16 cycles, `sweep_done` pulse on cycle 17, `sweep_hits`=3.
- Sweep interactions: `req0_valid` held during the sweep → `req0_ready`=0 throughout, first accept in the done cycle. Assert `rst` at sweep index 7 → no `sweep_done`, `sweep_hits`=0.
- Macro off: pulse `sweep_start` with `req0_valid`=1 → `sweep_busy` and `sweep_done` stay 0, and `req0` is accepted in the same cycle.

Source files
------------

// File: rtl/lut_1596_arb.sv
// lut_1596_arb: two-port round-robin arbiter in front of the shared lut_1596 decoder.
// Optional self-test sweep over all 16 codes is built only when LUT_SWEEP_EN is defined.
`ifndef Aone
`define Aone 4'd3
`endif
`ifndef Bone
`define Bone 4'd9
`endif
`ifndef Cone
`define Cone 4'd12
`endif

module lut_1596_arb #(
    parameter int HIT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [3:0]       req0_x,
    output logic             req0_ready,
    output logic             rsp0_valid,
    output logic             rsp0_y,
    input  logic             req1_valid,
    input  logic [3:0]       req1_x,
    output logic             req1_ready,
    output logic             rsp1_valid,
    output logic             rsp1_y,
    input  logic             sweep_start,
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic [HIT_W-1:0] sweep_hits
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SWEEP = 1'b1;

    // Port granted most recently; reset value 1 makes port 0 win the first tie.
    logic       last_grant;
    logic       blocked;
    logic       grant0;
    logic       grant1;
    logic [3:0] lut_x;
    logic       lut_y;

    function automatic logic [HIT_W-1:0] next_hits(input logic [HIT_W-1:0] cnt, input logic hit);
        return cnt + {{(HIT_W-1){1'b0}}, hit};
    endfunction

`ifdef LUT_SWEEP_EN
    logic [0:0]       state;
    logic [3:0]       idx;
    logic [HIT_W-1:0] hit_cnt;

    // A start sampled in IDLE already steals the decoder for this cycle.
    assign blocked    = (state == SWEEP) || sweep_start;
    assign lut_x      = (state == SWEEP) ? idx : (grant1 ? req1_x : req0_x);
    assign sweep_busy = (state == SWEEP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= 4'd0;
            hit_cnt    <= '0;
            sweep_done <= 1'b0;
            sweep_hits <= '0;
        end else begin
            sweep_done <= 1'b0;
            if (state == IDLE) begin
                if (sweep_start) begin
                    state   <= SWEEP;
                    idx     <= 4'd0;
                    hit_cnt <= '0;
                end
            end else begin
                idx     <= idx + 4'd1;
                hit_cnt <= next_hits(hit_cnt, lut_y);
                if (idx == 4'd15) begin
                    state      <= IDLE;
                    sweep_done <= 1'b1;
                    sweep_hits <= next_hits(hit_cnt, lut_y);
                end
            end
        end
    end
`else
    logic unused_sweep_start;

    assign unused_sweep_start = sweep_start;
    assign blocked    = 1'b0;
    assign lut_x      = grant1 ? req1_x : req0_x;
    assign sweep_busy = 1'b0;
    assign sweep_done = 1'b0;
    assign sweep_hits = '0;
`endif

    assign grant0     = !blocked && req0_valid && (!req1_valid || last_grant);
    assign grant1     = !blocked && req1_valid && (!req0_valid || !last_grant);
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    lut_1596 u_lut (
        .x (lut_x),
        .y (lut_y)
    );

    // Response stage: result of this cycle's accepted lookup, visible next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_y     <= 1'b0;
            rsp1_y     <= 1'b0;
        end else begin
            rsp0_valid <= grant0;
            rsp1_valid <= grant1;
            if (grant0) begin
                rsp0_y     <= lut_y;
                last_grant <= 1'b0;
            end
            if (grant1) begin
                rsp1_y     <= lut_y;
                last_grant <= 1'b1;
            end
        end
    end

endmodule

// Shared 4-bit decoder: y is 1 for the three codes of the hit set.
module lut_1596 (
    input  logic [3:0] x,
    output logic       y
);
    assign y = (x == `Aone) || (x == `Bone) || (x == `Cone);
endmodule

// File: tb/tb_lut_1596_arb.sv
// Self-checking bench for lut_1596_arb: vector table, hand-written corner sequences,
// and randomized traffic checked against a cycle-level reference model.
`ifndef Aone
`define Aone 4'd3
`endif
`ifndef Bone
`define Bone 4'd9
`endif
`ifndef Cone
`define Cone 4'd12
`endif

module tb_lut_1596_arb;

`ifdef LUT_SWEEP_EN
    localparam bit SWEEP_ON = 1'b1;
`else
    localparam bit SWEEP_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid, sweep_start;
    logic [3:0] req0_x, req1_x;
    logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_y, rsp1_y;
    logic       sweep_busy, sweep_done;
    logic [4:0] sweep_hits;

    always #5 clk = ~clk;

    lut_1596_arb #(.HIT_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_x      (req0_x),
        .req0_ready  (req0_ready),
        .rsp0_valid  (rsp0_valid),
        .rsp0_y      (rsp0_y),
        .req1_valid  (req1_valid),
        .req1_x      (req1_x),
        .req1_ready  (req1_ready),
        .rsp1_valid  (rsp1_valid),
        .rsp1_y      (rsp1_y),
        .sweep_start (sweep_start),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done),
        .sweep_hits  (sweep_hits)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int last;
    int exp_y0, exp_y1;
    int sw_rem;
    int hits_exp;
    int total;
    int got_r0, got_r1;

    typedef struct {
        bit         v0;
        logic [3:0] x0;
        bit         v1;
        logic [3:0] x1;
        bit         e_r0;
        bit         e_r1;
        bit         e_y;
    } vec_t;

    vec_t       tbl[11];
    logic [3:0] ca, cb, cc, nh;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int hit(input logic [3:0] c);
        return ((c == `Aone) || (c == `Bone) || (c == `Cone)) ? 1 : 0;
    endfunction

    task automatic model_reset();
        last     = 1;
        exp_y0   = 0;
        exp_y1   = 0;
        sw_rem   = 0;
        hits_exp = 0;
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic cyc(input bit v0, input logic [3:0] x0, input bit v1, input logic [3:0] x1, input bit sst);
        int pick;
        bit blocked;
        bit start;
        int done_exp;
        req0_valid  = v0;
        req0_x      = x0;
        req1_valid  = v1;
        req1_x      = x1;
        sweep_start = sst;
        #1;
        blocked = SWEEP_ON && (sw_rem > 0 || sst);
        pick = -1;
        if (!blocked) begin
            if (v0 && v1)  pick = 1 - last;
            else if (v0)   pick = 0;
            else if (v1)   pick = 1;
        end
        got_r0 = int'(req0_ready);
        got_r1 = int'(req1_ready);
        chk("req0_ready", got_r0, (pick == 0) ? 1 : 0);
        chk("req1_ready", got_r1, (pick == 1) ? 1 : 0);
        start = SWEEP_ON && (sw_rem == 0) && sst;
        @(posedge clk);
        #1;
        if (pick == 0) begin last = 0; exp_y0 = hit(x0); end
        if (pick == 1) begin last = 1; exp_y1 = hit(x1); end
        done_exp = 0;
        if (sw_rem > 0) begin
            sw_rem--;
            if (sw_rem == 0) begin
                done_exp = 1;
                hits_exp = total;
            end
        end
        if (start) sw_rem = 16;
        chk("rsp0_valid", int'(rsp0_valid), (pick == 0) ? 1 : 0);
        chk("rsp1_valid", int'(rsp1_valid), (pick == 1) ? 1 : 0);
        chk("rsp0_y", int'(rsp0_y), exp_y0);
        chk("rsp1_y", int'(rsp1_y), exp_y1);
        chk("sweep_busy", int'(sweep_busy), (sw_rem > 0) ? 1 : 0);
        chk("sweep_done", int'(sweep_done), done_exp);
        chk("sweep_hits", int'(sweep_hits), hits_exp);
    endtask

    // Asynchronous reset taken mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_rsp0_valid", int'(rsp0_valid), 0);
        chk("rst_rsp1_valid", int'(rsp1_valid), 0);
        chk("rst_rsp0_y", int'(rsp0_y), 0);
        chk("rst_rsp1_y", int'(rsp1_y), 0);
        chk("rst_sweep_busy", int'(sweep_busy), 0);
        chk("rst_sweep_done", int'(sweep_done), 0);
        chk("rst_sweep_hits", int'(sweep_hits), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int busy_cnt;
        bit found;
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; sweep_start = 1'b0;
        req0_x = 4'd0; req1_x = 4'd0;
        ca = `Aone; cb = `Bone; cc = `Cone;
        total = 0;
        found = 1'b0;
        nh = 4'd0;
        for (int c = 0; c < 16; c++) begin
            total += hit(c[3:0]);
            if (!found && hit(c[3:0]) == 0) begin
                nh = c[3:0];
                found = 1'b1;
            end
        end
        model_reset();
        #3;
        do_reset();

        tbl[0]  = '{1'b1, ca, 1'b1, cb, 1'b1, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, nh, 1'b1, cb, 1'b0, 1'b1, 1'b1};
        tbl[2]  = '{1'b1, nh, 1'b1, ca, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, cc, 1'b1, nh, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, cc, 1'b1, nh, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, ca, 1'b1, nh, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, nh, 1'b0, cb, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, cb, 1'b0, nh, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, ca, 1'b1, cb, 1'b0, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, ca, 1'b1, nh, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, ca, 1'b0, cb, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].v0, tbl[i].x0, tbl[i].v1, tbl[i].x1, 1'b0);
            chk("tbl_ready0", got_r0, int'(tbl[i].e_r0));
            chk("tbl_ready1", got_r1, int'(tbl[i].e_r1));
            chk("tbl_rsp0_valid", int'(rsp0_valid), int'(tbl[i].e_r0));
            chk("tbl_rsp1_valid", int'(rsp1_valid), int'(tbl[i].e_r1));
            if (tbl[i].e_r0) chk("tbl_rsp0_y", int'(rsp0_y), int'(tbl[i].e_y));
            if (tbl[i].e_r1) chk("tbl_rsp1_y", int'(rsp1_y), int'(tbl[i].e_y));
        end

        // Reset in the middle of traffic, then a tie goes to port 0.
        cyc(1'b1, ca, 1'b1, cb, 1'b0);
        cyc(1'b1, ca, 1'b1, cb, 1'b0);
        #2;
        do_reset();
        cyc(1'b1, ca, 1'b1, cb, 1'b0);
        chk("rr_after_reset", got_r0, 1);

`ifdef LUT_SWEEP_EN
        cyc(1'b1, nh, 1'b0, 4'd0, 1'b1);
        chk("start_blocks_ready", got_r0, 0);
        busy_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (sweep_busy) busy_cnt++;
            cyc(1'b1, nh, 1'b0, 4'd0, 1'b0);
            chk("sweep_holds_req0", got_r0, 0);
        end
        chk("sweep_busy_cycles", busy_cnt, 16);
        chk("sweep_done_pulse", int'(sweep_done), 1);
        chk("sweep_hits_final", int'(sweep_hits), 3);
        chk("sweep_busy_end", int'(sweep_busy), 0);
        cyc(1'b1, nh, 1'b0, 4'd0, 1'b0);
        chk("accept_in_done_cycle", got_r0, 1);
        chk("hits_hold", int'(sweep_hits), 3);

        // Abort a sweep at index 7.
        cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 7; i++) cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        #2;
        do_reset();
        for (int i = 0; i < 20; i++) cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        chk("abort_hits_zero", int'(sweep_hits), 0);
`else
        cyc(1'b1, ca, 1'b0, 4'd0, 1'b1);
        chk("start_ignored_ready", got_r0, 1);
        chk("start_ignored_busy", int'(sweep_busy), 0);
        for (int i = 0; i < 18; i++) cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        chk("start_ignored_done", int'(sweep_done), 0);
        chk("start_ignored_hits", int'(sweep_hits), 0);
`endif

        // Randomized traffic against the model.
        #2;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                ($urandom_range(0, 19) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
